// File: rtl/uart_reg_bridge.sv
// UART byte-stream to register-bus bridge: decodes write/read frames, issues one
// bus request per complete frame and returns an ack, read data or error byte.
module uart_reg_bridge #(
  parameter int N_BYTES = 4,
  parameter int TIMEOUT = 1_000_000,
  localparam int DATA_W = 8 * N_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err_timeout
);

  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_DATA = CW'(N_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     byte_cnt;
  logic [CW-1:0]     rsp_last;
  logic [TW-1:0]     tmo_cnt;
  logic              is_rd;
  logic [DATA_W-1:0] rsp_sr;
  logic              rx_fire;
  logic              tx_fire;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      rsp_last    <= '0;
      tmo_cnt     <= '0;
      is_rd       <= 1'b0;
      rsp_sr      <= '0;
      rx_ready    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              state <= ADDR;
              is_rd <= (rx_data == CMD_RD);
            end else begin
              state    <= RESP;
              rx_ready <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= RSP_ERR;
              rsp_last <= '0;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            bus_addr <= rx_data;
            tmo_cnt  <= '0;
            if (is_rd) begin
              state    <= BUS;
              rx_ready <= 1'b0;
              bus_rd   <= 1'b1;
            end else begin
              state <= WDATA;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WDATA: begin
          // An accepted byte wins over a timeout expiring in the same cycle.
          if (rx_fire) begin
            bus_wdata <= (bus_wdata << 8) | DATA_W'(rx_data);
            tmo_cnt   <= '0;
            if (byte_cnt == LAST_DATA) begin
              state    <= BUS;
              byte_cnt <= '0;
              rx_ready <= 1'b0;
              bus_wr   <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            byte_cnt    <= '0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_wr   <= 1'b0;
            bus_rd   <= 1'b0;
            state    <= RESP;
            tx_valid <= 1'b1;
            if (is_rd) begin
              tx_data  <= bus_rdata[DATA_W-1 -: 8];
              rsp_sr   <= bus_rdata << 8;
              rsp_last <= LAST_DATA;
            end else begin
              tx_data  <= RSP_ACK;
              rsp_last <= '0;
            end
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (byte_cnt == rsp_last) begin
              state    <= IDLE;
              byte_cnt <= '0;
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              tx_data  <= rsp_sr[DATA_W-1 -: 8];
              rsp_sr   <= rsp_sr << 8;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: table of frames with expected bus activity, response
// bytes predicted into a queue, plus timeout and reset corner sequences.
module tb_uart_reg_bridge;

  localparam int NB  = 4;
  localparam int TMO = 16;
  localparam int DW  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wr;
  logic          bus_rd;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          err_timeout;

  always #5 clk = ~clk;

  uart_reg_bridge #(.N_BYTES(NB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    int          stall;
    logic        exp_wr;
    logic        exp_rd;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         err_at;
  int         pulses;
  logic       saw_bus;
  logic       saw_tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic collect_resp(input int stall);
    logic [7:0] e;
    int n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("tx_valid_wait", tx_valid, 1);
      for (int s = 0; s < stall; s++) begin
        check("tx_stall_data", tx_data, e);
        @(negedge clk);
      end
      check("tx_data", tx_data, e);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  // Entered at the negedge right after the final frame byte transferred.
  task automatic bus_and_resp(input vec_t v);
    if (v.cmd == 8'h57) exp_q.push_back(8'h4B);
    else if (v.cmd == 8'h52)
      for (int i = NB - 1; i >= 0; i--) exp_q.push_back(v.rdata[8*i +: 8]);
    else exp_q.push_back(8'h3F);

    check("bus_wr", bus_wr, v.exp_wr);
    check("bus_rd", bus_rd, v.exp_rd);
    if (v.exp_wr || v.exp_rd) begin
      check("bus_addr", bus_addr, v.addr);
      if (v.exp_wr) check("bus_wdata", bus_wdata, v.wdata);
      for (int i = 0; i < v.ack_dly; i++) begin
        @(negedge clk);
        check("bus_hold", {bus_wr, bus_rd}, {v.exp_wr, v.exp_rd});
      end
      bus_ack   = 1'b1;
      bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("bus_drop", {bus_wr, bus_rd}, 0);
      check("addr_stable", bus_addr, v.addr);
    end
    check("tx_valid_first", tx_valid, 1);
    collect_resp(v.stall);
    check("back_idle", {tx_valid, rx_ready}, 2'b01);
  endtask

  task automatic apply_vec(input vec_t v);
    send_byte(v.cmd);
    if (v.cmd == 8'h57 || v.cmd == 8'h52) send_byte(v.addr);
    if (v.cmd == 8'h57)
      for (int i = NB - 1; i >= 0; i--) send_byte(v.wdata[8*i +: 8]);
    bus_and_resp(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h57, 8'h10, 32'hDEADBEEF, 32'h0,        3, 0, 1'b1, 1'b0};
    tbl[1] = '{8'h52, 8'h22, 32'h0,        32'h01020304, 2, 5, 1'b0, 1'b1};
    tbl[2] = '{8'h41, 8'h00, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0};
    tbl[3] = '{8'h52, 8'h00, 32'h0,        32'hCAFEF00D, 0, 1, 1'b0, 1'b1};
    tbl[4] = '{8'h57, 8'hFF, 32'h00000001, 32'h0,        1, 2, 1'b1, 1'b0};
    tbl[5] = '{8'h52, 8'hFF, 32'h0,        32'hFFFFFFFF, 4, 0, 1'b0, 1'b1};

    // Reset values
    #22;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_bus_req", {bus_wr, bus_rd}, 0);
    check("rst_err", err_timeout, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_rst", rx_ready, 1);

    for (int i = 0; i < 6; i++) apply_vec(tbl[i]);

    // Inter-byte timeout on a partial write frame
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'hAA);
    err_at = -1; pulses = 0; saw_bus = 1'b0; saw_tx = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        if (err_at < 0) err_at = i;
      end
      if (bus_wr || bus_rd) saw_bus = 1'b1;
      if (tx_valid) saw_tx = 1'b1;
    end
    check("tmo_cycle", err_at, TMO);
    check("tmo_pulses", pulses, 1);
    check("tmo_no_bus", saw_bus, 0);
    check("tmo_no_tx", saw_tx, 0);
    check("tmo_rx_ready", rx_ready, 1);
    apply_vec('{8'h52, 8'h10, 32'h0, 32'h55AA1234, 1, 0, 1'b0, 1'b1});

    // Byte accepted exactly when the timeout counter sits at TIMEOUT-1
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h11);
    check("edge_no_tmo", err_timeout, 0);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    bus_and_resp('{8'h57, 8'h20, 32'h11223344, 32'h0, 0, 0, 1'b1, 1'b0});

    // Reset while a write is outstanding, followed by a late ack
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("pre_rst_bus_wr", bus_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_bus_wr", bus_wr, 0);
    check("async_rx_ready", rx_ready, 0);
    check("async_bus_addr", bus_addr, 0);
    check("async_bus_wdata", bus_wdata, 0);
    check("async_tx_data", tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h87654321;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    saw_bus = 1'b0; saw_tx = 1'b0;
    repeat (4) begin
      if (bus_wr || bus_rd) saw_bus = 1'b1;
      if (tx_valid) saw_tx = 1'b1;
      @(negedge clk);
    end
    check("late_ack_no_bus", saw_bus, 0);
    check("late_ack_no_tx", saw_tx, 0);
    check("late_ack_idle", rx_ready, 1);
    apply_vec('{8'h52, 8'h33, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 The block SHALL have parameter N_BYTES, default 4: data bytes per register word (1-4); DATA_W = 8*N_BYTES.
REQ-002 The block SHALL have parameter TIMEOUT, default 1_000_000: inter-byte timeout in clk cycles (>=2).
REQ-003 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port rx_data, input, 8: received byte from the UART receiver.
REQ-006 Port rx_valid, input, 1: rx_data valid.
REQ-007 Port rx_ready, output, 1: bridge accepts rx_data; a byte transfers when rx_valid & rx_ready.
REQ-008 Port tx_data, output, 8: response byte to the UART transmitter.
REQ-009 Port tx_valid, output, 1: tx_data valid.
REQ-010 Port tx_ready, input, 1: transmitter accepts; a byte transfers when tx_valid & tx_ready.
REQ-011 Port bus_addr, output, 8: register address.
REQ-012 Port bus_wdata, output, DATA_W: write data.
REQ-013 Port bus_wr, output, 1: write request, held until bus_ack.
REQ-014 Port bus_rd, output, 1: read request, held until bus_ack.
REQ-015 Port bus_ack, input, 1: one-cycle completion strobe from the register file.
REQ-016 Port bus_rdata, input, DATA_W: read data, valid in the bus_ack cycle.
REQ-017 Port err_timeout, output, 1: one-cycle pulse on frame abort.

Function
REQ-018 Frames SHALL be: write = 0x57, ADDR, N_BYTES data bytes MSB first; read = 0x52, ADDR.
REQ-019 States SHALL be IDLE, ADDR, WDATA, BUS, RESP.
REQ-020 rx_ready SHALL be 1 only in IDLE, ADDR and WDATA, and 0 in BUS and RESP.
REQ-021 Transitions SHALL be:
- IDLE: 0x57 or 0x52 -> ADDR.
- IDLE: any other byte -> RESP with the single response 0x3F.
- ADDR: byte -> WDATA for a write, BUS for a read.
- WDATA: after the N_BYTES-th byte -> BUS.
- BUS: bus_ack -> RESP.
- RESP: after the last response byte transfers -> IDLE.
REQ-022 bus_addr and bus_wdata SHALL hold the captured values, stable from entry to BUS until the next frame's capture.
REQ-023 bus_wr or bus_rd SHALL assert in the first cycle of BUS, i.e. one cycle after the final frame byte transfers, and deassert in the cycle after bus_ack.
REQ-024 bus_rdata SHALL be captured in the bus_ack cycle; bus_ack outside BUS SHALL be ignored.
REQ-025 BUS SHALL wait for bus_ack indefinitely, with no timeout.
REQ-026 The write response SHALL be the single byte 0x4B; the read response SHALL be N_BYTES bytes of the captured rdata, MSB first.
REQ-027 tx_valid SHALL assert in the first RESP cycle; tx_data SHALL be stable while tx_valid & ~tx_ready.
REQ-028 A byte counter of width >= $clog2(N_BYTES+1) SHALL count data bytes in WDATA and response bytes in RESP, and SHALL clear on every state change.
REQ-029 A timeout counter SHALL run only in ADDR and WDATA, and SHALL clear on every accepted byte and on leaving those states.
REQ-030 At count TIMEOUT-1 the block SHALL go to IDLE, pulse err_timeout for one cycle and send no response.
REQ-031 A byte accepted in the same cycle the timeout would fire SHALL take precedence, with no abort.
REQ-032 A partial frame SHALL never cause bus activity.

Reset
REQ-033 While rst_n = 0, all of the following SHALL hold immediately, without waiting for clk:
- state = IDLE; both counters = 0.
- rx_ready = 0; tx_valid = 0; bus_wr = 0; bus_rd = 0; err_timeout = 0.
- bus_addr = 0; bus_wdata = 0; tx_data = 0.
REQ-034 rx_ready SHALL be 1 in the first cycle after rst_n rises.
REQ-035 Reset mid-frame or mid-bus SHALL drop the frame and issue no response; a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-036 N_BYTES=4: send 57 10 DE AD BE EF -> bus_wr=1 with addr 0x10, wdata 0xDEADBEEF; ack after 3 cycles -> tx byte 0x4B, then IDLE.
REQ-037 Send 52 22 with rdata 0x01020304 on ack -> bus_rd=1 with addr 0x22; tx 01 02 03 04 in order, held through 5 cycles of tx_ready=0 stalls.
REQ-038 Send 0x41 -> tx 0x3F, no bus activity; the next frame 52 00 is served normally.
REQ-039 TIMEOUT=16: send 57 10 AA then idle -> err_timeout pulses exactly once, 16 cycles after the AA transfer; no bus_wr; the next 52 10 frame completes.
REQ-040 Assert rst_n=0 while bus_wr=1, then apply a late bus_ack -> bus_wr drops asynchronously; no tx; state is IDLE.
REQ-041 Accept a byte in exactly the cycle the timeout counter hits TIMEOUT-1 -> no err_timeout; the frame continues.
